// File: rtl/multibyte_add_ctrl.sv
// Byte-serial add/subtract sequencer: one 8-bit adder is reused LSB-first
// across NBYTES slices, with the carry rippling between cycles.
module multibyte_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   in1,
    input  logic [8*NBYTES-1:0]   in2,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  count
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic                  accept_s;
    logic                  last_s;
    logic [8*NBYTES-1:0]   a_r;
    logic [8*NBYTES-1:0]   b_r;
    logic                  sub_r;
    logic                  carry_r;
    logic [IDX_W-1:0]      idx_r;
    logic [8*NBYTES-1:0]   sum_r;
    logic                  count_r;
    logic                  busy_r;
    logic                  done_r;
    logic [7:0]            a_byte_s;
    logic [7:0]            b_byte_s;
    logic [7:0]            b_op_s;
    logic [8:0]            add_s;

    // Next-state decode and the shared byte adder.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_s       = (idx_r == LAST_IDX);
        a_byte_s     = a_r[{idx_r, 3'b000} +: 8];
        b_byte_s     = b_r[{idx_r, 3'b000} +: 8];
        // Subtraction is A + ~B + 1; the +1 comes from the carry seeded at accept.
        if (sub_r) begin
            b_op_s = ~b_byte_s;
        end else begin
            b_op_s = b_byte_s;
        end
        add_s = {1'b0, a_byte_s} + {1'b0, b_op_s} + {8'd0, carry_r};
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    next_state_s = RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, per-byte result update and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            count_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_r == RUN);
            done_r <= (state_r == DONE);
            if (accept_s) begin
                a_r     <= in1;
                b_r     <= in2;
                sub_r   <= sub;
                carry_r <= sub ? 1'b1 : cin;
                idx_r   <= '0;
            end else if (state_r == RUN) begin
                sum_r[{idx_r, 3'b000} +: 8] <= add_s[7:0];
                carry_r <= add_s[8];
                if (last_s) begin
                    count_r <= add_s[8];
                    idx_r   <= '0;
                end else begin
                    idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end else begin
                carry_r <= carry_r;
            end
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign count = count_r;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench for multibyte_add_ctrl (NBYTES=4) with hand-computed results.
module tb_multibyte_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        count;

    int total_checks;
    int passed_checks;

    multibyte_add_ctrl #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .in1   (in1),
        .in2   (in2),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start high across one rising edge (the accept edge).
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c);
        in1   = a;
        in2   = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen, bounded so a dead DUT cannot hang.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 20);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c,
                          input logic [31:0] exp_sum, input logic exp_count);
        int k;
        launch(a, b, s, c);
        wait_done(k);
        check_eq({tag, "_lat"}, 32'(k), 32'd5);
        check_eq({tag, "_sum"}, sum, exp_sum);
        check_eq({tag, "_cnt"}, {31'd0, count}, {31'd0, exp_count});
        tick();
        check_eq({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int dones;
        logic [31:0] seen_sum;

        total_checks  = 0;
        passed_checks = 0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        in1   = 32'd0;
        in2   = 32'd0;
        cin   = 1'b0;
        tick();
        tick();
        check_eq("rst_busy",  {31'd0, busy},  32'd0);
        check_eq("rst_done",  {31'd0, done},  32'd0);
        check_eq("rst_sum",   sum,            32'd0);
        check_eq("rst_count", {31'd0, count}, 32'd0);
        rst = 1'b0;
        tick();

        // Busy timing around the first operation.
        launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        check_eq("busy_t0", {31'd0, busy}, 32'd0);
        tick();
        check_eq("busy_t1", {31'd0, busy}, 32'd1);
        wait_done(k);
        check_eq("carry01_lat", 32'(k + 1), 32'd5);
        check_eq("carry01_sum", sum, 32'h0000_0100);
        check_eq("carry01_cnt", {31'd0, count}, 32'd0);
        check_eq("carry01_busy", {31'd0, busy}, 32'd0);
        tick();

        run_op("wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        run_op("add_ci", 32'd200,       32'd100,       1'b0, 1'b1, 32'h0000_012D, 1'b0);
        run_op("sub_nb", 32'd5,         32'd3,         1'b1, 1'b1, 32'h0000_0002, 1'b1);
        run_op("sub_bw", 32'd3,         32'd5,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);
        run_op("mixed",  32'h8000_00F0, 32'h8000_0020, 1'b0, 1'b0, 32'h0000_0110, 1'b1);

        // Start during RUN with new operands must be ignored.
        launch(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        dones    = 0;
        seen_sum = 32'd0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2) begin
                in1   = 32'hAAAA_AAAA;
                in2   = 32'h1111_1111;
                cin   = 1'b1;
                sub   = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                seen_sum = sum;
            end
        end
        check_eq("ign_dones", 32'(dones), 32'd1);
        check_eq("ign_sum", seen_sum, 32'h0000_0030);

        // Back-to-back: start presented while the first op sits in its DONE state.
        launch(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        in1   = 32'd8;
        in2   = 32'd9;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("b2b_done1", {31'd0, done}, 32'd1);
        check_eq("b2b_sum1", sum, 32'h1122_3344);
        wait_done(k);
        check_eq("b2b_lat2", 32'(k), 32'd5);
        check_eq("b2b_sum2", sum, 32'd17);
        check_eq("b2b_cnt2", {31'd0, count}, 32'd0);
        tick();

        // Reset in RUN cycle 2 aborts the operation with no done.
        launch(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy", {31'd0, busy},  32'd0);
        check_eq("abort_done", {31'd0, done},  32'd0);
        check_eq("abort_sum",  sum,            32'd0);
        check_eq("abort_cnt",  {31'd0, count}, 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        check_eq("abort_nodone", 32'(dones), 32'd0);
        run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
